// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice as a MAC over a vector of (a, b) pairs and returns the P result.
// Last accept to r_valid is P_LAT+1 cycles; s_ready is low from the last accept until the result is taken.
module dsp_mac_sequencer #(
   parameter int P_LAT       = 3,
   parameter int OPMODE_LEAD = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [17:0]      s_a,
   input  logic [17:0]      s_b,
   input  logic             s_last,
   output logic [17:0]      dsp_a,
   output logic [17:0]      dsp_b,
   output logic [7:0]       dsp_opmode,
   output logic             dsp_ceopmode,
   output logic             dsp_cea,
   output logic             dsp_ceb,
   output logic             dsp_cem,
   output logic             dsp_cep,
   output logic             dsp_rstp,
   input  logic [47:0]      dsp_p,
   input  logic             dsp_carryout,
   output logic             r_valid,
   input  logic             r_ready,
   output logic [47:0]      r_data,
   output logic [CNT_W-1:0] r_taps,
   output logic             r_cout
);
   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;
   typedef struct packed {
      logic vld;
      logic first;
      logic last;
   } tag_t;

   localparam int M_STG   = P_LAT - 2;
   localparam int P_STG   = P_LAT - 1;
   localparam int OPM_STG = P_LAT - 1 - OPMODE_LEAD;
   localparam logic [7:0] OPM_LOAD = 8'h01;
   localparam logic [7:0] OPM_ACC  = 8'h09;

   state_t           state_q, state_d;
   tag_t             tag_q [P_LAT];
   tag_t             tag_d [P_LAT];
   logic [1:0]       boot_q, boot_d;
   logic [17:0]      a_q, a_d, b_q, b_d;
   logic             ce_ab_q, ce_ab_d;
   logic [7:0]       opmode_q, opmode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, taps_q, taps_d;
   logic [47:0]      data_q, data_d;
   logic             rvld_q, rvld_d, rcout_q, rcout_d, cout_q, cout_d;
   logic             cep_dly_q, cep_dly_d, first_dly_q, first_dly_d, last_dly_q, last_dly_d;
   logic             acc, capture;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, ACCUM: if (acc) state_d = s_last ? DRAIN : ACCUM;
         DRAIN:       if (last_dly_q) state_d = HOLD;
         HOLD:        if (r_ready) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   // Ready is held off until the slice's P register has been cleared after reset.
   always_comb begin
      s_ready = boot_q[1] && (state_q == IDLE || state_q == ACCUM);
   end

   assign acc     = s_valid && s_ready;
   assign capture = (state_q == DRAIN) && last_dly_q;

   always_comb begin
      boot_d         = {boot_q[0], 1'b1};
      a_d            = acc ? s_a : a_q;
      b_d            = acc ? s_b : b_q;
      ce_ab_d        = acc;
      tag_d[0].vld   = acc;
      tag_d[0].first = acc && (state_q == IDLE);
      tag_d[0].last  = acc && s_last;
      for (int k = 1; k < P_LAT; k++) tag_d[k] = tag_q[k-1];

      opmode_d = opmode_q;
      if (tag_d[OPM_STG].vld) opmode_d = tag_d[OPM_STG].first ? OPM_LOAD : OPM_ACC;

      cnt_d = cnt_q;
      if (acc) begin
         if (state_q == IDLE)  cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
         else if (!(&cnt_q))   cnt_d = cnt_q + 1'b1;
      end

      // Carry-out is visible the cycle after each P update.
      cep_dly_d   = tag_q[P_STG].vld;
      first_dly_d = tag_q[P_STG].first;
      last_dly_d  = tag_q[P_STG].vld && tag_q[P_STG].last;
      cout_d      = cout_q;
      if (cep_dly_q) cout_d = first_dly_q ? dsp_carryout : (cout_q | dsp_carryout);

      data_d  = data_q;
      taps_d  = taps_q;
      rcout_d = rcout_q;
      rvld_d  = rvld_q;
      if (capture) begin
         data_d  = dsp_p;
         taps_d  = cnt_q;
         rcout_d = cout_d;
         rvld_d  = 1'b1;
      end else if (rvld_q && r_ready) begin
         rvld_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         boot_q      <= '0;
         a_q         <= '0;
         b_q         <= '0;
         ce_ab_q     <= 1'b0;
         opmode_q    <= '0;
         cnt_q       <= '0;
         taps_q      <= '0;
         data_q      <= '0;
         rvld_q      <= 1'b0;
         rcout_q     <= 1'b0;
         cout_q      <= 1'b0;
         cep_dly_q   <= 1'b0;
         first_dly_q <= 1'b0;
         last_dly_q  <= 1'b0;
         for (int k = 0; k < P_LAT; k++) tag_q[k] <= '0;
      end else begin
         boot_q      <= boot_d;
         a_q         <= a_d;
         b_q         <= b_d;
         ce_ab_q     <= ce_ab_d;
         opmode_q    <= opmode_d;
         cnt_q       <= cnt_d;
         taps_q      <= taps_d;
         data_q      <= data_d;
         rvld_q      <= rvld_d;
         rcout_q     <= rcout_d;
         cout_q      <= cout_d;
         cep_dly_q   <= cep_dly_d;
         first_dly_q <= first_dly_d;
         last_dly_q  <= last_dly_d;
         for (int k = 0; k < P_LAT; k++) tag_q[k] <= tag_d[k];
      end
   end

   assign dsp_a        = a_q;
   assign dsp_b        = b_q;
   assign dsp_cea      = ce_ab_q;
   assign dsp_ceb      = ce_ab_q;
   assign dsp_cem      = tag_q[M_STG].vld;
   assign dsp_cep      = tag_q[P_STG].vld;
   assign dsp_ceopmode = tag_q[OPM_STG].vld;
   assign dsp_opmode   = opmode_q;
   assign dsp_rstp     = boot_q[0] && !boot_q[1];
   assign r_valid      = rvld_q;
   assign r_data       = data_q;
   assign r_taps       = taps_q;
   assign r_cout       = rcout_q;
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: two builds (P_LAT=3/LEAD=1 and P_LAT=2/LEAD=0), each feeding a behavioural slice.
module tb_dsp_mac_sequencer;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Shared stimulus; sel steers it to build 1 (0) or build 2 (1).
   logic        sel = 1'b0;
   logic        in_valid = 1'b0, in_last = 1'b0, res_ready = 1'b1;
   logic [17:0] in_a = '0, in_b = '0;

   logic s1_ready, s2_ready;
   logic [17:0] d1_a, d1_b, d2_a, d2_b;
   logic [7:0]  d1_opm, d2_opm;
   logic d1_ceop, d1_cea, d1_ceb, d1_cem, d1_cep, d1_rstp;
   logic d2_ceop, d2_cea, d2_ceb, d2_cem, d2_cep, d2_rstp;
   logic [47:0] d1_p = '0, d2_p = '0;
   logic d1_co = 1'b0, d2_co = 1'b0;
   logic r1_valid, r2_valid, r1_cout, r2_cout;
   logic [47:0] r1_data, r2_data;
   logic [CNT_W-1:0] r1_taps, r2_taps;

   dsp_mac_sequencer #(.P_LAT(3), .OPMODE_LEAD(1), .CNT_W(CNT_W)) u1 (
      .clk(clk), .rst_n(rst_n), .s_valid(in_valid && !sel), .s_ready(s1_ready),
      .s_a(in_a), .s_b(in_b), .s_last(in_last),
      .dsp_a(d1_a), .dsp_b(d1_b), .dsp_opmode(d1_opm), .dsp_ceopmode(d1_ceop),
      .dsp_cea(d1_cea), .dsp_ceb(d1_ceb), .dsp_cem(d1_cem), .dsp_cep(d1_cep), .dsp_rstp(d1_rstp),
      .dsp_p(d1_p), .dsp_carryout(d1_co),
      .r_valid(r1_valid), .r_ready(res_ready), .r_data(r1_data), .r_taps(r1_taps), .r_cout(r1_cout));

   dsp_mac_sequencer #(.P_LAT(2), .OPMODE_LEAD(0), .CNT_W(CNT_W)) u2 (
      .clk(clk), .rst_n(rst_n), .s_valid(in_valid && sel), .s_ready(s2_ready),
      .s_a(in_a), .s_b(in_b), .s_last(in_last),
      .dsp_a(d2_a), .dsp_b(d2_b), .dsp_opmode(d2_opm), .dsp_ceopmode(d2_ceop),
      .dsp_cea(d2_cea), .dsp_ceb(d2_ceb), .dsp_cem(d2_cem), .dsp_cep(d2_cep), .dsp_rstp(d2_rstp),
      .dsp_p(d2_p), .dsp_carryout(d2_co),
      .r_valid(r2_valid), .r_ready(res_ready), .r_data(r2_data), .r_taps(r2_taps), .r_cout(r2_cout));

   // Slice 1: A1/B1, M and P registers, registered opmode.
   logic signed [17:0] a1 = '0, b1 = '0;
   logic signed [35:0] m1 = '0;
   logic [7:0] opm1 = '0;
   always @(posedge clk) begin
      if (d1_cea) a1 <= d1_a;
      if (d1_ceb) b1 <= d1_b;
      if (d1_cem) m1 <= a1 * b1;
      if (d1_ceop) opm1 <= d1_opm;
      if (d1_rstp) {d1_co, d1_p} <= '0;
      else if (d1_cep)
         {d1_co, d1_p} <= {1'b0, (opm1[3:2] == 2'b10) ? d1_p : 48'd0} + {1'b0, {12{m1[35]}}, m1};
   end

   // Slice 2: A1/B1 and P registers only, unregistered opmode.
   logic signed [17:0] a2 = '0, b2 = '0;
   logic signed [35:0] m2;
   assign m2 = a2 * b2;
   always @(posedge clk) begin
      if (d2_cea) a2 <= d2_a;
      if (d2_ceb) b2 <= d2_b;
      if (d2_rstp) {d2_co, d2_p} <= '0;
      else if (d2_cep)
         {d2_co, d2_p} <= {1'b0, (d2_opm[3:2] == 2'b10) ? d2_p : 48'd0} + {1'b0, {12{m2[35]}}, m2};
   end

   logic             m_s_ready, m_r_valid, m_r_cout, m_cep, m_ceop, m_rstp;
   logic [47:0]      m_r_data;
   logic [CNT_W-1:0] m_r_taps;
   logic [7:0]       m_opm;
   assign m_s_ready = sel ? s2_ready : s1_ready;
   assign m_r_valid = sel ? r2_valid : r1_valid;
   assign m_r_data  = sel ? r2_data  : r1_data;
   assign m_r_taps  = sel ? r2_taps  : r1_taps;
   assign m_r_cout  = sel ? r2_cout  : r1_cout;
   assign m_cep     = sel ? d2_cep   : d1_cep;
   assign m_ceop    = sel ? d2_ceop  : d1_ceop;
   assign m_opm     = sel ? d2_opm   : d1_opm;
   assign m_rstp    = sel ? d2_rstp  : d1_rstp;

   int         cep_cnt = 0;
   logic [7:0] opm_log [$];
   always @(negedge clk) begin
      if (m_cep) cep_cnt++;
      if (m_ceop) opm_log.push_back(m_opm);
   end

   // Reference: the vector's dot product modulo 2^48, carries from each accumulating add.
   int         va [$];
   int         vb [$];
   logic [47:0] exp_sum;
   logic        exp_cout;
   int          last_acc;

   function automatic void calc_model();
      longint     prod;
      logic [48:0] t;
      exp_sum  = '0;
      exp_cout = 1'b0;
      for (int k = 0; k < va.size(); k++) begin
         prod = longint'(va[k]) * longint'(vb[k]);
         if (k == 0) exp_sum = prod[47:0];
         else begin
            t        = {1'b0, exp_sum} + {1'b0, prod[47:0]};
            exp_sum  = t[47:0];
            exp_cout = exp_cout | t[48];
         end
      end
   endfunction

   task automatic send_pair(input int a, input int b, input logic last);
      int n = 0;
      in_valid = 1'b1; in_a = 18'(a); in_b = 18'(b); in_last = last;
      while (!m_s_ready && n < 50) begin @(negedge clk); n++; end
      if (!m_s_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: s_ready got %b required 1", m_s_ready);
      end
      @(negedge clk);
      last_acc = cyc;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic drive_vec(input int gap);
      for (int k = 0; k < va.size(); k++) begin
         send_pair(va[k], vb[k], k == va.size() - 1);
         if (k != va.size() - 1) repeat (gap < 0 ? $urandom_range(0, 3) : gap) @(negedge clk);
      end
   endtask

   task automatic wait_result(input string name, input int lat);
      int n = 0;
      while (!m_r_valid && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (m_r_valid !== 1'b1) begin
         errors++; $display("FAIL %s_timeout: r_valid got %b required 1", name, m_r_valid);
      end else begin
         checks++;
         if (cyc - last_acc !== lat) begin
            errors++; $display("FAIL %s_latency: got %0d required %0d", name, cyc - last_acc, lat);
         end
         checks++;
         if (m_r_data !== exp_sum) begin
            errors++; $display("FAIL %s_data: got %h required %h", name, m_r_data, exp_sum);
         end
         checks++;
         if (m_r_taps !== CNT_W'(va.size())) begin
            errors++; $display("FAIL %s_taps: got %0d required %0d", name, m_r_taps, va.size());
         end
         checks++;
         if (m_r_cout !== exp_cout) begin
            errors++; $display("FAIL %s_cout: got %b required %b", name, m_r_cout, exp_cout);
         end
      end
   endtask

   task automatic wait_release(input string name);
      int n = 0;
      while (m_r_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (m_r_valid !== 1'b0) begin
         errors++; $display("FAIL %s_release: r_valid got %b required 0", name, m_r_valid);
      end
   endtask

   task automatic run_vec(input string name, input int gap);
      calc_model();
      drive_vec(gap);
      wait_result(name, sel ? 3 : 4);
      wait_release(name);
   endtask

   task automatic load4();
      va = '{1, 3, 5, 7};
      vb = '{2, 4, 6, 8};
   endtask

   task automatic check_opmodes(input string name);
      checks++;
      if (opm_log.size() !== 4) begin
         errors++; $display("FAIL %s_opm_count: got %0d required 4", name, opm_log.size());
      end
      for (int k = 0; k < opm_log.size() && k < 4; k++) begin
         checks++;
         if (opm_log[k] !== (k == 0 ? 8'h01 : 8'h09)) begin
            errors++;
            $display("FAIL %s_opm%0d: got %h required %h", name, k, opm_log[k], (k == 0 ? 8'h01 : 8'h09));
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({m_s_ready, m_r_valid, m_rstp, m_cep, m_ceop, d1_cea, m_opm, m_r_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: s_ready=%b r_valid=%b rstp=%b cep=%b opm=%h r_data=%h required all 0",
                  m_s_ready, m_r_valid, m_rstp, m_cep, m_opm, m_r_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({m_rstp, m_s_ready} !== 2'b10) begin
         errors++; $display("FAIL reset_cycle1: rstp,s_ready got %b%b required 10", m_rstp, m_s_ready);
      end
      @(negedge clk);
      checks++;
      if ({m_rstp, m_s_ready} !== 2'b01) begin
         errors++; $display("FAIL reset_cycle2: rstp,s_ready got %b%b required 01", m_rstp, m_s_ready);
      end
   endtask

   task automatic test_single_tap();
      va = '{3};
      vb = '{-5};
      run_vec("single", 0);
   endtask

   task automatic test_back_to_back();
      load4();
      opm_log.delete();
      run_vec("b2b", 0);
      check_opmodes("b2b");
   endtask

   task automatic test_gaps();
      load4();
      cep_cnt = 0;
      run_vec("gaps", 2);
      checks++;
      if (cep_cnt !== 4) begin
         errors++; $display("FAIL gaps_cep_count: got %0d required 4", cep_cnt);
      end
   endtask

   task automatic test_backpressure();
      va.delete(); vb.delete();
      for (int k = 0; k < 3; k++) begin
         va.push_back(int'($urandom_range(0, 262143)) - 131072);
         vb.push_back(int'($urandom_range(0, 262143)) - 131072);
      end
      res_ready = 1'b0;
      calc_model();
      drive_vec(0);
      wait_result("bp", 4);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({m_r_valid, m_s_ready} !== 2'b10 || m_r_data !== exp_sum) begin
            errors++;
            $display("FAIL bp_hold%0d: r_valid=%b s_ready=%b r_data=%h required 1 0 %h",
                     i, m_r_valid, m_s_ready, m_r_data, exp_sum);
         end
      end
      res_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({m_r_valid, m_s_ready} !== 2'b01) begin
         errors++; $display("FAIL bp_release: r_valid,s_ready got %b%b required 01", m_r_valid, m_s_ready);
      end
      va = '{2};
      vb = '{2};
      run_vec("bp_next", 0);
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      send_pair(11, 12, 1'b0);
      send_pair(13, 14, 1'b0);
      in_valid = 1'b1; in_a = 18'd15; in_b = 18'd16; in_last = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (m_rstp !== 1'b1) begin
         errors++; $display("FAIL midrst_rstp: got %b required 1", m_rstp);
      end
      for (int i = 0; i < 10; i++) begin
         if (m_r_valid) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL midrst_no_result: r_valid seen %b required 0", seen);
      end
      va = '{9};
      vb = '{9};
      run_vec("midrst_fresh", 0);
   endtask

   task automatic test_extremes();
      va = '{-131072, -131072};
      vb = '{-131072, -131072};
      run_vec("extreme", 0);
   endtask

   task automatic test_random(input int nvec);
      for (int v = 0; v < nvec; v++) begin
         va.delete(); vb.delete();
         for (int k = 0; k < $urandom_range(1, 8); k++) begin
            va.push_back(int'($urandom_range(0, 262143)) - 131072);
            vb.push_back(int'($urandom_range(0, 262143)) - 131072);
         end
         run_vec($sformatf("rand%0d_sel%0d", v, sel), -1);
      end
   endtask

   task automatic test_plat2();
      sel = 1'b1;
      @(negedge clk);
      load4();
      opm_log.delete();
      run_vec("plat2_b2b", 0);
      check_opmodes("plat2_b2b");
      test_random(3);
      sel = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_tap();
      test_back_to_back();
      test_gaps();
      test_backpressure();
      test_reset_mid();
      test_extremes();
      test_random(6);
      test_plat2();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
